pipeline_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 4-stage RISC CPU (IF, DOF, EX, WB). It keeps a two-entry scoreboard of in-flight register writes and detects read-after-write hazards for the instruction in DOF. On a hazard it stalls IF/DOF and injects a bubble into EX. It also flushes IF and DOF when EX resolves a taken branch or jump, and it keeps saturating stall and flush counters for performance monitoring.

---
 rtl/pipeline_hazard_ctrl.sv | 110 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - RAW hazard stall, branch flush and perf counters for the 4-stage pipe
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_dec_rw,
    input  logic [4:0]       i_dec_da,
    input  logic [4:0]       i_dec_aa,
    input  logic [4:0]       i_dec_ba,
    input  logic             i_dec_ma,
    input  logic             i_dec_mb,
    input  logic             i_ex_taken,
    output logic             o_pc_hold,
    output logic             o_ir_hold,
    output logic             o_dof_bubble,
    output logic             o_if_flush,
    output logic             o_dof_flush,
    output logic             o_ir_valid,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             r_ir_valid;
    logic             r_ex_v;
    logic [4:0]       r_ex_da;
    logic             r_wb_v;
    logic [4:0]       r_wb_da;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_use_a;
    logic w_use_b;
    logic w_hit_a;
    logic w_hit_b;
    logic w_haz;
    logic w_flush;
    logic w_stall;
    logic w_ex_v_next;

    // No bypass path: both EX and WB entries block a reader until the write lands.
    always_comb begin
        w_use_a     = r_ir_valid & ~i_dec_ma & (i_dec_aa != 5'd0);
        w_use_b     = r_ir_valid & ~i_dec_mb & (i_dec_ba != 5'd0);
        w_hit_a     = (r_ex_v & (r_ex_da == i_dec_aa)) | (r_wb_v & (r_wb_da == i_dec_aa));
        w_hit_b     = (r_ex_v & (r_ex_da == i_dec_ba)) | (r_wb_v & (r_wb_da == i_dec_ba));
        w_haz       = (w_use_a & w_hit_a) | (w_use_b & w_hit_b);
        w_flush     = i_ex_taken;
        w_stall     = ~i_ex_taken & w_haz;
        w_ex_v_next = r_ir_valid & i_dec_rw & (i_dec_da != 5'd0);
    end

    always_comb begin
        o_pc_hold    = 1'b0;
        o_ir_hold    = 1'b0;
        o_dof_bubble = 1'b0;
        o_if_flush   = 1'b0;
        o_dof_flush  = 1'b0;
        if (!reset) begin
            o_pc_hold    = w_stall;
            o_ir_hold    = w_stall;
            o_dof_bubble = w_stall;
            o_if_flush   = w_flush;
            o_dof_flush  = w_flush;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ir_valid  <= 1'b0;
            r_ex_v      <= 1'b0;
            r_ex_da     <= 5'd0;
            r_wb_v      <= 1'b0;
            r_wb_da     <= 5'd0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            // The branch itself keeps moving to WB so its own write still retires.
            r_wb_v  <= r_ex_v;
            r_wb_da <= r_ex_da;
            if (w_flush || w_stall) begin
                r_ex_v  <= 1'b0;
                r_ex_da <= 5'd0;
            end else begin
                r_ex_v  <= w_ex_v_next;
                r_ex_da <= i_dec_da;
            end

            if (w_flush) begin
                r_ir_valid <= 1'b0;
            end else if (!w_stall) begin
                r_ir_valid <= 1'b1;
            end

            if (w_stall && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign o_ir_valid  = r_ir_valid;
    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench with a register-ready-time reference model
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             i_dec_rw;
    logic [4:0]       i_dec_da;
    logic [4:0]       i_dec_aa;
    logic [4:0]       i_dec_ba;
    logic             i_dec_ma;
    logic             i_dec_mb;
    logic             i_ex_taken;
    logic             o_pc_hold;
    logic             o_ir_hold;
    logic             o_dof_bubble;
    logic             o_if_flush;
    logic             o_dof_flush;
    logic             o_ir_valid;
    logic [CNT_W-1:0] o_stall_cnt;
    logic [CNT_W-1:0] o_flush_cnt;

    pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_dec_rw    (i_dec_rw),
        .i_dec_da    (i_dec_da),
        .i_dec_aa    (i_dec_aa),
        .i_dec_ba    (i_dec_ba),
        .i_dec_ma    (i_dec_ma),
        .i_dec_mb    (i_dec_mb),
        .i_ex_taken  (i_ex_taken),
        .o_pc_hold   (o_pc_hold),
        .o_ir_hold   (o_ir_hold),
        .o_dof_bubble(o_dof_bubble),
        .o_if_flush  (o_if_flush),
        .o_dof_flush (o_dof_flush),
        .o_ir_valid  (o_ir_valid),
        .o_stall_cnt (o_stall_cnt),
        .o_flush_cnt (o_flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] ctl;
        logic       v;
        int         sc;
        int         fc;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: a register is readable from the cycle its write retires, three
    // cycles after the writer leaves DOF. Anything reading it earlier must wait.
    int   ready_at [32];
    int   cyc   = 0;
    bit   m_v   = 0;
    int   m_sc  = 0;
    int   m_fc  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk($sformatf("ctl[ph,ih,bub,iff,dff] cyc%0d", e.cyc),
                int'({o_pc_hold, o_ir_hold, o_dof_bubble, o_if_flush, o_dof_flush}), int'(e.ctl));
            chk($sformatf("ir_valid cyc%0d", e.cyc), int'(o_ir_valid), int'(e.v));
            chk($sformatf("stall_cnt cyc%0d", e.cyc), int'(o_stall_cnt), e.sc);
            chk($sformatf("flush_cnt cyc%0d", e.cyc), int'(o_flush_cnt), e.fc);
        end
    end

    task automatic step(input logic rst, input logic rw, input logic [4:0] da,
                        input logic [4:0] aa, input logic [4:0] ba,
                        input logic ma, input logic mb, input logic tk, output logic st);
        exp_t e;
        bit hz;
        bit fl;
        @(posedge clk);
        #1;
        reset = rst; i_dec_rw = rw; i_dec_da = da; i_dec_aa = aa; i_dec_ba = ba;
        i_dec_ma = ma; i_dec_mb = mb; i_ex_taken = tk;
        e.v = m_v; e.sc = m_sc; e.fc = m_fc; e.cyc = cyc; e.ctl = 5'b0;
        st = 1'b0;
        if (rst) begin
            m_v = 0; m_sc = 0; m_fc = 0;
            for (int r = 0; r < 32; r++) ready_at[r] = 0;
        end else begin
            hz = m_v && ((!ma && aa != 0 && ready_at[aa] > cyc) ||
                         (!mb && ba != 0 && ready_at[ba] > cyc));
            fl = tk;
            st = !fl && hz;
            if (fl) e.ctl = 5'b00011;
            else if (st) e.ctl = 5'b11100;
            if (!fl && !st && m_v && rw && da != 0) ready_at[da] = cyc + 3;
            if (st && m_sc < CMAX) m_sc++;
            if (fl && m_fc < CMAX) m_fc++;
            if (fl) m_v = 0;
            else if (!st) m_v = 1;
        end
        q.push_back(e);
        cyc++;
    endtask

    task automatic issue(input logic rw, input logic [4:0] da, input logic [4:0] aa,
                         input logic [4:0] ba, input logic ma, input logic mb);
        logic st;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, rw, da, aa, ba, ma, mb, 1'b0, st);
            if (!st) return;
        end
        chk("issue_timeout", 1, 0);
    endtask

    task automatic do_reset();
        logic st;
        step(1'b1, 0, 0, 0, 0, 0, 0, 0, st);
        step(1'b0, 0, 0, 0, 0, 0, 0, 0, st);
    endtask

    initial begin
        logic st;
        logic       rw, ma, mb, tk, rst;
        logic [4:0] da, aa, ba;
        for (int r = 0; r < 32; r++) ready_at[r] = 0;
        reset = 1'b1; i_dec_rw = 0; i_dec_da = 0; i_dec_aa = 0; i_dec_ba = 0;
        i_dec_ma = 0; i_dec_mb = 0; i_ex_taken = 0;
        repeat (2) @(posedge clk);
        do_reset();

        // back-to-back dependency
        issue(1, 5'd1, 5'd2, 5'd3, 0, 0);
        issue(1, 5'd4, 5'd1, 5'd5, 0, 0);
        @(negedge clk);
        chk("b2b_stall_cnt", int'(o_stall_cnt), 2);

        // one-gap and two-gap
        do_reset();
        issue(1, 5'd7, 5'd2, 5'd3, 0, 0);
        issue(0, 5'd0, 5'd0, 5'd0, 0, 0);
        issue(1, 5'd8, 5'd7, 5'd0, 0, 0);
        @(negedge clk);
        chk("gap1_stall_cnt", int'(o_stall_cnt), 1);
        do_reset();
        issue(1, 5'd7, 5'd2, 5'd3, 0, 0);
        issue(0, 5'd0, 5'd0, 5'd0, 0, 0);
        issue(0, 5'd0, 5'd0, 5'd0, 0, 0);
        issue(1, 5'd8, 5'd0, 5'd7, 0, 0);
        @(negedge clk);
        chk("gap2_stall_cnt", int'(o_stall_cnt), 0);

        // no false hazards: R0, MB, MA
        do_reset();
        issue(1, 5'd0, 5'd2, 5'd3, 0, 0);
        issue(1, 5'd5, 5'd0, 5'd0, 0, 0);
        issue(1, 5'd3, 5'd2, 5'd2, 0, 0);
        issue(1, 5'd6, 5'd4, 5'd3, 0, 1);
        issue(1, 5'd3, 5'd2, 5'd2, 0, 0);
        issue(1, 5'd6, 5'd3, 5'd4, 1, 0);
        @(negedge clk);
        chk("false_haz_stall_cnt", int'(o_stall_cnt), 0);

        // taken branch over a pending hazard
        do_reset();
        issue(1, 5'd1, 5'd2, 5'd3, 0, 0);
        issue(0, 5'd0, 5'd4, 5'd5, 0, 0);
        step(1'b0, 1, 5'd9, 5'd1, 5'd1, 0, 0, 1'b1, st);
        @(negedge clk);
        chk("branch_if_flush", int'(o_if_flush), 1);
        chk("branch_pc_hold", int'(o_pc_hold), 0);
        step(1'b0, 1, 5'd10, 5'd9, 5'd9, 0, 0, 1'b0, st);
        @(negedge clk);
        chk("post_flush_ir_valid", int'(o_ir_valid), 0);
        chk("post_flush_flush_cnt", int'(o_flush_cnt), 1);
        issue(1, 5'd11, 5'd9, 5'd9, 0, 0);
        @(negedge clk);
        chk("killed_not_recorded", int'(o_stall_cnt), 0);

        // stall counter saturation
        do_reset();
        for (int k = 0; k < 11; k++) issue(1, 5'd1, 5'd1, 5'd1, 0, 0);
        @(negedge clk);
        chk("stall_cnt_saturates", int'(o_stall_cnt), CMAX);

        // reset in the second cycle of a 2-cycle stall
        do_reset();
        issue(1, 5'd1, 5'd2, 5'd3, 0, 0);
        step(1'b0, 1, 5'd4, 5'd1, 5'd5, 0, 0, 0, st);
        step(1'b1, 1, 5'd4, 5'd1, 5'd5, 0, 0, 0, st);
        step(1'b0, 1, 5'd4, 5'd1, 5'd5, 0, 0, 0, st);
        @(negedge clk);
        chk("rst_mid_stall_pc_hold", int'(o_pc_hold), 0);
        chk("rst_mid_stall_cnt", int'(o_stall_cnt), 0);
        issue(1, 5'd4, 5'd1, 5'd5, 0, 0);
        @(negedge clk);
        chk("rst_mid_stall_no_stall", int'(o_stall_cnt), 0);

        // randomized traffic; the decode inputs are held while stalled, as IR would be
        rw = 0; da = 0; aa = 0; ba = 0; ma = 0; mb = 0;
        st = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (!st) begin
                rw = 1'($urandom_range(0, 3) != 0);
                da = 5'($urandom_range(0, 7));
                aa = 5'($urandom_range(0, 7));
                ba = 5'($urandom_range(0, 7));
                ma = 1'($urandom_range(0, 5) == 0);
                mb = 1'($urandom_range(0, 3) == 0);
            end
            tk  = 1'($urandom_range(0, 9) == 0);
            rst = 1'($urandom_range(0, 199) == 0);
            step(rst, rw, da, aa, ba, ma, mb, tk, st);
        end

        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
        @(posedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
